// File: rtl/rcpfa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rcpfa_pkg
//  Purpose  : Shared types and constants for the rcpfa serial subtractor.
//             Holds the handshake FSM state type and the width of the
//             optional mismatch counter.
//  Revision : 1.0  initial release
// ============================================================================
package rcpfa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ERRCNT_W = 16;

endpackage : rcpfa_pkg
`default_nettype wire

// File: rtl/rcpfa_sub_cell.sv
`default_nettype none
// ============================================================================
//  Module   : rcpfa_sub_cell
//  Purpose  : One-bit combinational subtractor cell, exact or approximate.
//  Ports    : i_a, i_b     minuend / subtrahend bit
//             i_br         incoming borrow
//             i_approxEn   1 = borrow-free bit (d = a^b, borrow-out is the
//                          bit's own generate term only)
//             o_d          difference bit
//             o_br         outgoing borrow
//  Revision : 1.0  initial release
// ============================================================================
module rcpfa_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_br,
  input  logic i_approxEn,
  output logic o_d,
  output logic o_br
);

  logic w_prop;
  logic w_gen;

  assign w_prop = i_a ^ i_b;
  assign w_gen  = ~i_a & i_b;

  // In approximate mode the incoming borrow is ignored, and the borrow-out
  // is just this bit's generate term. That term becomes the borrow-in of
  // the first exact bit, so no ripple runs through the approximate region.
  assign o_d  = i_approxEn ? w_prop : (w_prop ^ i_br);
  assign o_br = i_approxEn ? w_gen  : (w_gen | (~w_prop & i_br));

endmodule : rcpfa_sub_cell
`default_nettype wire

// File: rtl/rcpfa_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : rcpfa_serial_sub
//  Purpose  : Bit-serial approximate subtractor d = a - b, LSB first, one bit
//             per clock. The low APPROX_BITS bits use a borrow-free
//             difference. The upper bits subtract exactly.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             in_valid/in_ready   operand handshake (a, b)
//             a, b                minuend, subtrahend (WIDTH)
//             out_valid/out_ready result handshake (diff, bout)
//             diff                approximate difference (WIDTH)
//             bout                borrow out of the MSB (1 = underflow)
//             err_flag, err_cnt   present only with RCPFA_SUB_ERRSTAT_EN:
//                                 result differs from exact / saturating
//                                 count of mismatched results handed off
//  Config   : `define RCPFA_SUB_ERRSTAT_EN enables a parallel exact borrow
//             chain and the error statistics ports.
//  Revision : 1.0  initial release
// ============================================================================
module rcpfa_serial_sub
  import rcpfa_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef RCPFA_SUB_ERRSTAT_EN
  ,
  output logic                err_flag,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int c_idxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // One extra bit so that APPROX_BITS == WIDTH is representable.
  localparam logic [c_idxW:0]   c_approxBits = (c_idxW + 1)'(APPROX_BITS);
  localparam logic [c_idxW-1:0] c_lastIdx    = c_idxW'(WIDTH - 1);

  state_t             r_state;
  logic               r_inReady;
  logic               r_outValid;
  logic [WIDTH-1:0]   r_aSh;
  logic [WIDTH-1:0]   r_bSh;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;
  logic [c_idxW-1:0]  r_idx;
  logic               r_br;

  logic w_approxEn;
  logic w_d;
  logic w_br;

  assign w_approxEn = ({1'b0, r_idx} < c_approxBits);

  rcpfa_sub_cell u_cell (
    .i_a        (r_aSh[0]),
    .i_b        (r_bSh[0]),
    .i_br       (r_br),
    .i_approxEn (w_approxEn),
    .o_d        (w_d),
    .o_br       (w_br)
  );

  // Operands shift right so the current bit is always at position 0.
  // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
      r_idx      <= '0;
      r_br       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_aSh     <= a;
            r_bSh     <= b;
            r_idx     <= '0;
            r_br      <= 1'b0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_aSh  <= r_aSh >> 1;
          r_bSh  <= r_bSh >> 1;
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_br   <= w_br;
          r_idx  <= r_idx + 1'b1;
          if (r_idx == c_lastIdx) begin
            r_bout     <= w_br;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here even on the hand-off cycle.
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign diff      = r_diff;
  assign bout      = r_bout;

`ifdef RCPFA_SUB_ERRSTAT_EN
  logic                r_exBr;
  logic                r_mis;
  logic                r_errFlag;
  logic [ERRCNT_W-1:0] r_errCnt;
  logic                w_exD;
  logic                w_exBr;

  rcpfa_sub_cell u_exactCell (
    .i_a        (r_aSh[0]),
    .i_b        (r_bSh[0]),
    .i_br       (r_exBr),
    .i_approxEn (1'b0),
    .o_d        (w_exD),
    .o_br       (w_exBr)
  );

  // The exact chain runs alongside the approximate one. A sticky flag
  // records any differing difference bit, so no exact result word is stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exBr    <= 1'b0;
      r_mis     <= 1'b0;
      r_errFlag <= 1'b0;
      r_errCnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_exBr <= 1'b0;
            r_mis  <= 1'b0;
          end
        end
        RUN: begin
          r_exBr <= w_exBr;
          r_mis  <= r_mis | (w_d ^ w_exD);
          if (r_idx == c_lastIdx) begin
            r_errFlag <= r_mis | (w_d ^ w_exD) | (w_br ^ w_exBr);
          end
        end
        DONE: begin
          if (out_ready && r_errFlag && (r_errCnt != '1)) begin
            r_errCnt <= r_errCnt + 1'b1;
          end
        end
        default: begin
          r_mis <= 1'b0;
        end
      endcase
    end
  end

  assign err_flag = r_errFlag;
  assign err_cnt  = r_errCnt;
`endif

endmodule : rcpfa_serial_sub
`default_nettype wire

// File: tb/tb_rcpfa_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rcpfa_serial_sub
//  Purpose  : Self-checking bench for rcpfa_serial_sub. It drives two
//             instances from the same inputs. dutA uses APPROX_BITS=3 and
//             dutE uses APPROX_BITS=0 (exact). Results are compared with an
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rcpfa_serial_sub;
  import rcpfa_pkg::*;

  localparam int W  = 8;
  localparam int AB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         inReadyA, outValidA, boutA;
  logic [W-1:0] diffA;
  logic         inReadyE, outValidE, boutE;
  logic [W-1:0] diffE;
`ifdef RCPFA_SUB_ERRSTAT_EN
  logic                errFlagA, errFlagE;
  logic [ERRCNT_W-1:0] errCntA, errCntE;
  int                  cntModel = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] lastA, lastE;

  rcpfa_serial_sub #(.WIDTH(W), .APPROX_BITS(AB)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyA),
    .a(a), .b(b), .out_valid(outValidA), .out_ready(out_ready),
    .diff(diffA), .bout(boutA)
`ifdef RCPFA_SUB_ERRSTAT_EN
    , .err_flag(errFlagA), .err_cnt(errCntA)
`endif
  );

  rcpfa_serial_sub #(.WIDTH(W), .APPROX_BITS(0)) dutE (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyE),
    .a(a), .b(b), .out_valid(outValidE), .out_ready(out_ready),
    .diff(diffE), .bout(boutE)
`ifdef RCPFA_SUB_ERRSTAT_EN
    , .err_flag(errFlagE), .err_cnt(errCntE)
`endif
  );

  // Reference: low ab bits are XOR. The upper field is an ordinary integer
  // subtraction, with the generate of bit ab-1 as its borrow-in.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input int ab);
    int   br, hi, upMask, lowMask;
    logic g;
    logic [7:0] d;
    logic bo;
    if (ab >= 8) begin
      d  = x ^ y;
      bo = ~x[7] & y[7];
    end else begin
      lowMask = (1 << ab) - 1;
      upMask  = (1 << (8 - ab)) - 1;
      br = 0;
      if (ab > 0) begin
        g  = ~x[ab-1] & y[ab-1];
        br = g ? 1 : 0;
      end
      hi = int'(x >> ab) - int'(y >> ab) - br;
      bo = (hi < 0);
      d  = 8'(((hi & upMask) << ab) | (int'(x ^ y) & lowMask));
    end
    return {bo, d};
  endfunction

  function automatic logic [8:0] exact(input logic [7:0] x, input logic [7:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction. Called at #1 after an edge with both DUTs in IDLE.
  task automatic runOp(input logic [7:0] x, input logic [7:0] y, input int hold);
    logic [8:0] expA, expE;
    int lat;
    expA = model(x, y, AB);
    expE = model(x, y, 0);
    in_valid = 1'b1;
    a = x;
    b = y;
    tick();
    check("busyInReady", {inReadyA, inReadyE}, 2'b00);
    // Operand changes while busy must be ignored.
    a = 8'($urandom);
    b = 8'($urandom);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      tick();
      if (outValidA === 1'b1) lat = n;
    end
    check("latency", lat, W);
    check("resultA", {boutA, diffA}, expA);
    check("resultE", {outValidE, boutE, diffE}, {1'b1, expE});
    lastA = {boutA, diffA};
    lastE = {boutE, diffE};
`ifdef RCPFA_SUB_ERRSTAT_EN
    check("errFlagA", errFlagA, (expA != exact(x, y)));
    check("errFlagE", errFlagE, 0);
    if (expA != exact(x, y)) cntModel++;
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      check("holdStable", {outValidA, inReadyA, boutA, diffA}, {1'b1, 1'b0, expA});
    end
    // in_valid is still high on the hand-off edge; it must not be accepted.
    out_ready = 1'b1;
    tick();
    check("handoff", {outValidA, inReadyA, outValidE, inReadyE}, 4'b0101);
`ifdef RCPFA_SUB_ERRSTAT_EN
    check("errCnt", errCntA, cntModel);
`endif
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] op;
    logic        wasReady;
    logic        seen;
    int          lastT;
    int          nres;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("resetState", {inReadyA, outValidA, boutA, diffA}, {1'b1, 1'b0, 1'b0, 8'h00});
`ifdef RCPFA_SUB_ERRSTAT_EN
    check("resetErrCnt", errCntA, 0);
`endif

    // Directed vectors with known answers.
    runOp(8'h50, 8'h23, 20);
    check("vec50_23", lastA, 9'h033);
    runOp(8'h05, 8'h10, 0);
    check("vec05_10", lastA, 9'h1F5);
    runOp(8'h00, 8'h01, 0);
    check("vecE00_01", lastE, 9'h1FF);
    runOp(8'hFF, 8'hFF, 1);
    check("vecEFF_FF", lastE, 9'h000);
    runOp(8'h00, 8'hFF, 0);
    runOp(8'hFF, 8'h00, 2);
    runOp(8'h80, 8'h7F, 0);

    // Random operands with random backpressure.
    for (int i = 0; i < 16; i++) begin
      runOp(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset in RUN after bits 0..3 are processed (idx == 4).
    in_valid = 1'b1;
    a = 8'h9C;
    b = 8'h37;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("preRstBusy", {inReadyA, outValidA}, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstMid", {outValidA, inReadyA}, 2'b01);
    seen = 1'b0;
    repeat (W + 4) begin
      tick();
      if (outValidA !== 1'b0) seen = 1'b1;
    end
    check("noResultAfterRst", seen, 0);
`ifdef RCPFA_SUB_ERRSTAT_EN
    cntModel = 0;
    check("rstErrCnt", errCntA, 0);
`endif

    // Back-to-back: in_valid and out_ready held high.
    lastT = -1;
    nres = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 8'($urandom);
    b = 8'($urandom);
    for (int k = 0; k < 84; k++) begin
      if (k == 70) in_valid = 1'b0;
      wasReady = inReadyA;
      tick();
      if (wasReady && in_valid) begin
        q.push_back({a, b});
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (outValidA === 1'b1) begin
        if (q.size() == 0) begin
          check("b2bSpurious", 1, 0);
        end else begin
          op = q.pop_front();
          check("b2bResult", {boutA, diffA}, model(op[15:8], op[7:0], AB));
`ifdef RCPFA_SUB_ERRSTAT_EN
          if (model(op[15:8], op[7:0], AB) != exact(op[15:8], op[7:0])) cntModel++;
`endif
        end
        if (lastT >= 0) check("b2bSpacing", k - lastT, W + 2);
        lastT = k;
        nres++;
      end
    end
    check("b2bDrained", q.size(), 0);
    check("b2bCountOk", (nres >= 6), 1);
    check("b2bIdle", {inReadyA, outValidA}, 2'b10);
`ifdef RCPFA_SUB_ERRSTAT_EN
    check("b2bErrCnt", errCntA, cntModel);
`endif
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rcpfa_serial_sub
`default_nettype wire
